// File: rtl/lock_pkg.sv
// Shared types and helpers for the lock requester.
//   ch_state_e     : per-channel FSM state (IDLE/REQ/OWN/REL)
//   ch_rsp_t       : per-channel response bundle driven by lock_req_channel
//   onehot0_check  : 1 when at most one bit of the (zero-extended) vector is set
package lock_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } ch_state_e;

  typedef struct packed {
    logic ready;
    logic req;
    logic done;
    logic busy;
  } ch_rsp_t;

  // Clearing the lowest set bit leaves zero only for zero- or one-hot input.
  function automatic logic onehot0_check(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/lock_req_channel.sv
// One requester channel: accepts a hold-length job, requests the lock,
// counts owned cycles (surviving preemption), then releases for one cycle
// while pulsing done.
//   clk, rst_n  : clock, async active-low reset
//   job_valid   : job offer; accepted whenever the channel is IDLE
//   job_len     : owned cycles to hold (0 is treated as 1)
//   grant       : this channel's grant bit from the arbiter
//   rsp         : ready/req/done/busy, all decoded from the state register
module lock_req_channel
  import lock_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  input  logic             grant,
  output ch_rsp_t          rsp
);

  ch_state_e        state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             owned;
  logic             last;

  // req is a pure decode of the state flop, so it drops the instant reset
  // clears the state and never depends combinationally on grant.
  assign rsp.req   = (state_q == REQ) || (state_q == OWN);
  assign rsp.done  = (state_q == REL);
  assign rsp.busy  = (state_q != IDLE);
  assign rsp.ready = (state_q == IDLE);

  assign owned = rsp.req && grant;
  assign last  = (rem_q == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          rem_d   = (job_len == '0) ? LEN_W'(1) : job_len;
          state_d = REQ;
        end
      end
      REQ: begin
        if (owned) begin
          if (last) begin
            state_d = REL;
          end else begin
            rem_d   = rem_q - LEN_W'(1);
            state_d = OWN;
          end
        end
      end
      OWN: begin
        if (owned) begin
          // rem stops at 1 on the final owned cycle so it can never wrap.
          if (last) begin
            state_d = REL;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end else begin
          // Preempted: keep the remaining count and keep requesting.
          state_d = REQ;
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/lock_requester.sv
// Requester-side companion to the fixed-priority lock arbiter. Holds N_CH
// independent channels and watches the returned grant vector for protocol
// violations.
//   job_valid/job_len/job_ready : per-channel job handshake
//   req/grant                   : lock request / grant vectors
//   done                        : one-cycle pulse per completed job
//   busy                        : channel not IDLE
//   proto_err/err_clr           : sticky arbiter-violation flag and its clear
module lock_requester
  import lock_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       job_valid,
  input  logic [N_CH*LEN_W-1:0] job_len,
  output logic [N_CH-1:0]       job_ready,
  output logic [N_CH-1:0]       req,
  input  logic [N_CH-1:0]       grant,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       busy,
  output logic                  proto_err,
  input  logic                  err_clr
);

  ch_rsp_t [N_CH-1:0] rsp;
  logic               err_set;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lock_req_channel #(.LEN_W(LEN_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .job_valid (job_valid[i]),
      .job_len   (job_len[i*LEN_W +: LEN_W]),
      .grant     (grant[i]),
      .rsp       (rsp[i])
    );
    assign job_ready[i] = rsp[i].ready;
    assign req[i]       = rsp[i].req;
    assign done[i]      = rsp[i].done;
    assign busy[i]      = rsp[i].busy;
  end

  // Violation: more than one grant, or a grant to a channel not requesting.
  assign err_set = !onehot0_check(32'(grant)) || |(grant & ~req);

  // A violation in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        proto_err <= 1'b0;
    else if (err_set)  proto_err <= 1'b1;
    else if (err_clr)  proto_err <= 1'b0;
  end

endmodule

// File: tb/tb_lock_requester.sv
module tb_lock_requester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  job_valid = '0;
  logic [15:0] job_len = '0;
  logic [3:0]  job_ready, req, grant, done, busy;
  logic        proto_err;
  logic        err_clr = 1'b0;

  logic        force_en = 1'b0;
  logic [3:0]  force_val = '0;

  int nvec = 0;
  int nerr = 0;

  // Reference: pend = owned cycles still owed, rel = release/done cycle.
  int pend [4];
  bit rel  [4];
  bit m_err;

  always #5 clk = ~clk;

  lock_requester #(.N_CH(4), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_len(job_len),
    .job_ready(job_ready), .req(req), .grant(grant), .done(done),
    .busy(busy), .proto_err(proto_err), .err_clr(err_clr)
  );

  // Fixed-priority arbiter, bit 3 highest.
  function automatic logic [3:0] prio(input logic [3:0] r);
    for (int i = 3; i >= 0; i--) if (r[i]) return 4'b0001 << i;
    return 4'b0000;
  endfunction

  assign grant = force_en ? force_val : prio(req);

  function automatic logic [3:0] m_req();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (pend[i] > 0);
    return v;
  endfunction

  function automatic logic [3:0] m_done();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = rel[i];
    return v;
  endfunction

  function automatic logic [3:0] m_busy();
    return m_req() | m_done();
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin pend[i] = 0; rel[i] = 0; end
    m_err = 0;
  endtask

  // Advance one edge, updating the model with the inputs in force before it,
  // then settle 1 time unit past the edge for sampling.
  task automatic tick();
    logic [3:0] r, g;
    logic       set;
    int         len;
    r = m_req();
    g = force_en ? force_val : prio(r);
    @(posedge clk);
    set = ($countones(g) > 1) || ((g & ~r) != 0);
    if (set) m_err = 1;
    else if (err_clr) m_err = 0;
    for (int i = 0; i < 4; i++) begin
      if (rel[i]) rel[i] = 0;
      else if (pend[i] > 0) begin
        if (g[i]) begin
          pend[i]--;
          if (pend[i] == 0) rel[i] = 1;
        end
      end else if (job_valid[i]) begin
        len = int'(job_len[i*4 +: 4]);
        pend[i] = (len == 0) ? 1 : len;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    nvec++; if (req !== 4'h0) begin nerr++; $display("FAIL reset_req got %h want 0", req); end
    nvec++; if (done !== 4'h0) begin nerr++; $display("FAIL reset_done got %h want 0", done); end
    nvec++; if (busy !== 4'h0) begin nerr++; $display("FAIL reset_busy got %h want 0", busy); end
    nvec++; if (job_ready !== 4'hf) begin nerr++; $display("FAIL reset_ready got %h want f", job_ready); end
    nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", proto_err); end
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] er [1:5] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    logic [3:0] ed [1:5] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    logic       ey [1:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 1; c <= 5; c++) begin
      job_valid = (c == 1) ? 4'h1 : 4'h0;
      job_len   = 16'h0003;
      tick();
      nvec++; if (req !== er[c]) begin nerr++; $display("FAIL single_req c%0d got %h want %h", c, req, er[c]); end
      nvec++; if (done !== ed[c]) begin nerr++; $display("FAIL single_done c%0d got %h want %h", c, done, ed[c]); end
      nvec++; if (busy !== (er[c] | ed[c])) begin nerr++; $display("FAIL single_busy c%0d got %h want %h", c, busy, er[c] | ed[c]); end
      nvec++; if (job_ready[0] !== ey[c]) begin nerr++; $display("FAIL single_ready c%0d got %b want %b", c, job_ready[0], ey[c]); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] er [1:6] = '{4'h9, 4'h9, 4'h1, 4'h1, 4'h0, 4'h0};
    logic [3:0] ed [1:6] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    for (int c = 1; c <= 6; c++) begin
      job_valid = (c == 1) ? 4'h9 : 4'h0;
      job_len   = 16'h2002;
      tick();
      nvec++; if (req !== er[c]) begin nerr++; $display("FAIL simul_req c%0d got %h want %h", c, req, er[c]); end
      nvec++; if (done !== ed[c]) begin nerr++; $display("FAIL simul_done c%0d got %h want %h", c, done, ed[c]); end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] er [1:8] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h2, 4'h2, 4'h0, 4'h0};
    logic [3:0] ed [1:8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h2, 4'h0};
    for (int c = 1; c <= 8; c++) begin
      job_valid = (c == 1) ? 4'h2 : (c == 3) ? 4'h4 : 4'h0;
      job_len   = (c == 1) ? 16'h0040 : 16'h0200;
      tick();
      nvec++; if (req !== er[c]) begin nerr++; $display("FAIL preempt_req c%0d got %h want %h", c, req, er[c]); end
      nvec++; if (done !== ed[c]) begin nerr++; $display("FAIL preempt_done c%0d got %h want %h", c, done, ed[c]); end
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] er [1:3] = '{4'h4, 4'h0, 4'h0};
    logic [3:0] ed [1:3] = '{4'h0, 4'h4, 4'h0};
    for (int c = 1; c <= 3; c++) begin
      job_valid = (c == 1) ? 4'h4 : 4'h0;
      job_len   = 16'h0000;
      tick();
      nvec++; if (req !== er[c]) begin nerr++; $display("FAIL zero_req c%0d got %h want %h", c, req, er[c]); end
      nvec++; if (done !== ed[c]) begin nerr++; $display("FAIL zero_done c%0d got %h want %h", c, done, ed[c]); end
    end
    nvec++; if (job_ready !== 4'hf) begin nerr++; $display("FAIL zero_ready got %h want f", job_ready); end
  endtask

  task automatic test_proto_err();
    logic exp_e [1:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    job_valid = 4'h1; job_len = 16'h000f;
    tick();
    job_valid = 4'h0;
    nvec++; if (req !== 4'h1) begin nerr++; $display("FAIL perr_req got %h want 1", req); end
    nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL perr_clean got %b want 0", proto_err); end
    for (int c = 1; c <= 6; c++) begin
      force_en  = (c <= 2) || (c == 4);
      force_val = 4'h3;
      err_clr   = (c == 3) || (c == 4) || (c == 6);
      tick();
      nvec++; if (proto_err !== exp_e[c]) begin nerr++; $display("FAIL perr_flag c%0d got %b want %b", c, proto_err, exp_e[c]); end
    end
    force_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] er [1:4] = '{4'h8, 4'h8, 4'h0, 4'h0};
    logic [3:0] ed [1:4] = '{4'h0, 4'h0, 4'h8, 4'h0};
    job_valid = 4'h8; job_len = 16'h8000;
    tick();
    job_valid = 4'h0;
    tick();
    nvec++; if (req[3] !== 1'b1) begin nerr++; $display("FAIL rmid_own got %b want 1", req[3]); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (req !== 4'h0) begin nerr++; $display("FAIL rmid_req got %h want 0", req); end
    nvec++; if (busy !== 4'h0) begin nerr++; $display("FAIL rmid_busy got %h want 0", busy); end
    nvec++; if (job_ready !== 4'hf) begin nerr++; $display("FAIL rmid_ready got %h want f", job_ready); end
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      job_valid = (c == 1) ? 4'h8 : 4'h0;
      job_len   = 16'h2000;
      tick();
      nvec++; if (req !== er[c]) begin nerr++; $display("FAIL rmid2_req c%0d got %h want %h", c, req, er[c]); end
      nvec++; if (done !== ed[c]) begin nerr++; $display("FAIL rmid2_done c%0d got %h want %h", c, done, ed[c]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      job_valid = 4'($urandom) & 4'($urandom);
      job_len   = 16'($urandom);
      err_clr   = ($urandom_range(0, 15) == 0);
      force_en  = ($urandom_range(0, 24) == 0);
      force_val = 4'($urandom);
      tick();
      nvec++; if (req !== m_req()) begin nerr++; $display("FAIL rand_req c%0d got %h want %h", c, req, m_req()); end
      nvec++; if (done !== m_done()) begin nerr++; $display("FAIL rand_done c%0d got %h want %h", c, done, m_done()); end
      nvec++; if (busy !== m_busy()) begin nerr++; $display("FAIL rand_busy c%0d got %h want %h", c, busy, m_busy()); end
      nvec++; if (job_ready !== ~m_busy()) begin nerr++; $display("FAIL rand_ready c%0d got %h want %h", c, job_ready, ~m_busy()); end
      nvec++; if (proto_err !== m_err) begin nerr++; $display("FAIL rand_err c%0d got %b want %b", c, proto_err, m_err); end
    end
    job_valid = '0; err_clr = 1'b0; force_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_zero_len();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lock_requester.md
Name: lock_requester

Overview:
- Requester-side companion to the fixed-priority lock arbiter.
- Holds N_CH independent client channels. Each accepts a job (a hold length in cycles) over a valid/ready handshake, raises its req line, and counts cycles during which it owns the grant.
- Drops req after the requested number of owned cycles, then pulses done.
- Tolerates preemption by a higher-priority channel and flags arbiter protocol violations.
- Sits between client logic and the arbiter's req/grant vectors.

Parameters:
- N_CH, 4, number of channels; width of req and grant.
- LEN_W, 4, width of each job length field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- job_valid  in  N_CH  per-channel job offer.
- job_len  in  N_CH*LEN_W  per-channel hold length; channel i uses bits [i*LEN_W +: LEN_W].
- job_ready  out  N_CH  per-channel job accept.
- req  out  N_CH  lock request vector to the arbiter; registered.
- grant  in  N_CH  grant vector from the arbiter; may be combinational from req.
- done  out  N_CH  one-cycle pulse per completed job.
- busy  out  N_CH  channel is not in IDLE.
- proto_err  out  1  sticky arbiter-violation flag.
- err_clr  in  1  clears proto_err.

Behaviour:
- Reset, asynchronous on rst_n low:
  - req=0, done=0, busy=0, proto_err=0, all channels in IDLE, remaining counters=0.
  - job_ready is combinational from state, so it reads 1 for every channel.
  - req falls immediately on reset assertion, even mid-job.
- Per-channel FSM states: IDLE, REQ, OWN, REL.
- IDLE:
  - job_ready=1, req=0.
  - job_valid at the edge: latch rem=job_len, with job_len=0 treated as 1; go to REQ.
- Owned cycle: any cycle in REQ or OWN with req[i]=1 and grant[i]=1.
- REQ (req=1, waiting):
  - Owned cycle with rem>1: rem--, go to OWN.
  - Owned cycle with rem==1: go to REL.
  - Otherwise stay in REQ.
- OWN (req=1, holding):
  - Owned cycle: rem--; go to REL when rem was 1, else stay in OWN.
  - grant[i]=0: preempted. Go to REQ with rem unchanged; req stays high and the job resumes when re-granted.
- REL:
  - req=0 for exactly one cycle, done=1 for that same cycle.
  - Next state IDLE.
  - The gap is mandatory so lower-priority channels observe the lock release.
- busy=1 in REQ, OWN and REL.
- job_ready=0 outside IDLE. job_valid is ignored there; there is no queueing.
- Timing with immediate grant, job accepted at edge t and length L≥1:
  - req high in cycles t+1..t+L.
  - done and req=0 in cycle t+L+1.
  - job_ready=1 in cycle t+L+2.
- Counter width: rem is LEN_W bits and never wraps, since it never decrements below 1.
- proto_err sets at the next edge when either holds:
  - grant has more than one bit set;
  - any grant[i]=1 while req[i]=0.
- proto_err clears on err_clr. A set condition in the same cycle as err_clr wins.
- Channels are independent. Simultaneous job acceptance on several channels is legal.

Decomposition:
- Package lock_pkg:
  - state enum IDLE/REQ/OWN/REL;
  - default N_CH and LEN_W constants;
  - function onehot0_check.
- Sub-module lock_req_channel: one FSM plus rem counter, instantiated N_CH times by generate.
- Top level holds only the proto_err logic and the port slicing.

Test Plan:
All scenarios connect the priority_lock arbiter with bit 3 as highest priority. Times are cycle numbers relative to job acceptance at edge 0.
1. Single channel: ch0 job_len=3 accepted at edge 0 -> req=0001 in cycles 1-3; done[0]=1 and req=0000 in cycle 4; job_ready[0]=1 in cycle 5.
2. Simultaneous jobs: ch0 and ch3 both job_len=2 at edge 0 -> req=1001 in cycles 1-2 with grant=1000; ch3 done in cycle 3 while ch0 owns; ch0 owns cycles 3-4; done[0] in cycle 5.
3. Preemption: ch1 job_len=4 at edge 0; ch2 job_len=2 at edge 2 -> ch1 owns cycles 1-2; ch2 owns cycles 3-4; ch2 done in cycle 5 while ch1 resumes; ch1 owns cycles 5-6; done[1] in cycle 7.
4. Zero length: ch2 job_len=0 -> behaves exactly as job_len=1; one owned cycle, then done.
5. Protocol error: force grant=0011 while req=0001 -> proto_err=1 from the next cycle and stays set; err_clr pulse with a clean grant -> 0. Repeat with err_clr asserted during the violation -> stays 1.
6. Reset mid-job: rst_n low during OWN of ch3 with len 8 -> req=0000 immediately, busy=0, job_ready=1111. After release, a new job len 2 completes normally.
